user_pulser_sequencer: RTL and testbench

//  Sequences user_pulser through a table of up to Depth pulse configurations, with a repeat count.
//  - Sits between the user-domain register block and user_pulser.
//  - Drives the pulser's config, start and stop inputs, and watches its state_out.
//  - Software loads the table once, then issues one start for a whole multi-segment run.

---
 rtl/user_pulser_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_user_pulser_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_pulser_sequencer.sv
// Steps user_pulser through a table of pulse configurations, repeating the pass seq_loops_i times.
// Optional irq_o output is present only when USER_PULSER_SEQ_IRQ_EN is defined.
module user_pulser_sequencer #(
    parameter int unsigned  Depth      = 8,
    parameter int unsigned  ArmTimeout = 16,
    localparam int unsigned IdxW       = $clog2(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            tbl_we_i,
    input  logic [IdxW+1:0] tbl_addr_i,
    input  logic [31:0]     tbl_wdata_i,
    input  logic            seq_start_i,
    input  logic            seq_abort_i,
    input  logic [IdxW:0]   seq_len_i,
    input  logic [7:0]      seq_loops_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [IdxW-1:0] cur_idx_o,
    output logic [7:0]      pass_cnt_o,
    output logic            pls_start_o,
    output logic            pls_stop_o,
    output logic [15:0]     pls_f1_high_o,
    output logic [15:0]     pls_f1_end_o,
    output logic [15:0]     pls_f2_high_o,
    output logic [15:0]     pls_f2_end_o,
    output logic [7:0]      pls_f1_count_o,
    output logic [7:0]      pls_f2_count_o,
    output logic [7:0]      pls_stop_count_o,
`ifdef USER_PULSER_SEQ_IRQ_EN
    output logic            irq_o,
`endif
    input  logic [2:0]      pls_state_i
);

    localparam int unsigned     TmrW    = $clog2(ArmTimeout) + 1;
    localparam logic [TmrW-1:0] TmrMax  = TmrW'(ArmTimeout - 1);
    localparam logic [IdxW:0]   LenMax  = (IdxW + 1)'(Depth);
    localparam logic [2:0]      PlsIdle = 3'd0;
    localparam logic [2:0]      PlsDone = 3'd4;

    typedef struct packed {
        logic [15:0] f1_end;
        logic [15:0] f1_high;
        logic [15:0] f2_end;
        logic [15:0] f2_high;
        logic [7:0]  stop_cnt;
        logic [7:0]  f2_cnt;
        logic [7:0]  f1_cnt;
    } entry_t;

    typedef enum logic [2:0] {StIdle, StLoad, StFire, StArm, StRun, StNext, StDrain} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [7:0]      pass_q, pass_d, pass_inc;
    logic [IdxW:0]   len_q, len_d, idx_inc;
    logic [7:0]      loops_q, loops_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic            done_q, done_d, err_q, err_d, stop_q, stop_d;
    logic            done_set, err_set, flag_clr, load_cfg, ready;
    entry_t          tbl_q [Depth];
    entry_t          cfg_q;

    logic [IdxW-1:0] wr_entry;
    logic [1:0]      wr_word;
    logic            wr_ok;
    logic            unused_wdata_hi;

    assign wr_entry        = tbl_addr_i[IdxW+1:2];
    assign wr_word         = tbl_addr_i[1:0];
    assign wr_ok           = tbl_we_i && !busy_o && (wr_word != 2'd3) && ({1'b0, wr_entry} < LenMax);
    assign unused_wdata_hi = ^tbl_wdata_i[31:24];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tbl_q <= '{default: '0};
        end else if (wr_ok) begin
            case (wr_word)
                2'd0:    {tbl_q[wr_entry].f1_end, tbl_q[wr_entry].f1_high} <= tbl_wdata_i;
                2'd1:    {tbl_q[wr_entry].f2_end, tbl_q[wr_entry].f2_high} <= tbl_wdata_i;
                default: {tbl_q[wr_entry].stop_cnt, tbl_q[wr_entry].f2_cnt,
                          tbl_q[wr_entry].f1_cnt} <= tbl_wdata_i[23:0];
            endcase
        end
    end

    assign ready    = (pls_state_i == PlsIdle) || (pls_state_i == PlsDone);
    assign idx_inc  = {1'b0, idx_q} + 1'b1;
    assign pass_inc = (pass_q == 8'hff) ? pass_q : pass_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pass_d   = pass_q;
        len_d    = len_q;
        loops_d  = loops_q;
        tmr_d    = tmr_q;
        stop_d   = 1'b0;
        load_cfg = 1'b0;
        done_set = 1'b0;
        err_set  = 1'b0;
        flag_clr = 1'b0;
        if (seq_abort_i && (state_q != StIdle)) begin
            stop_d  = 1'b1;
            tmr_d   = '0;
            state_d = StDrain;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (seq_start_i) begin
                        if ((seq_len_i == '0) || (seq_len_i > LenMax)) begin
                            err_set = 1'b1;
                        end else begin
                            flag_clr = 1'b1;
                            idx_d    = '0;
                            pass_d   = '0;
                            len_d    = seq_len_i;
                            loops_d  = (seq_loops_i == 8'd0) ? 8'd1 : seq_loops_i;
                            load_cfg = 1'b1;
                            state_d  = StLoad;
                        end
                    end
                end
                StLoad: state_d = StFire;
                StFire: begin
                    tmr_d   = '0;
                    state_d = StArm;
                end
                StArm: begin
                    if (!ready) begin
                        state_d = StRun;
                    end else if (tmr_q == TmrMax) begin
                        err_set = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                StRun: if (pls_state_i == PlsDone) state_d = StNext;
                StNext: begin
                    if (idx_inc < len_q) begin
                        idx_d    = idx_inc[IdxW-1:0];
                        load_cfg = 1'b1;
                        state_d  = StLoad;
                    end else begin
                        pass_d = pass_inc;
                        if (pass_inc == loops_q) begin
                            done_set = 1'b1;
                            state_d  = StIdle;
                        end else begin
                            idx_d    = '0;
                            load_cfg = 1'b1;
                            state_d  = StLoad;
                        end
                    end
                end
                StDrain: begin
                    if (ready) begin
                        state_d = StIdle;
                    end else if (tmr_q == TmrMax) begin
                        err_set = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign done_d = done_set | (done_q & ~flag_clr);
    assign err_d  = err_set | (err_q & ~flag_clr);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            pass_q  <= '0;
            len_q   <= '0;
            loops_q <= '0;
            tmr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            len_q   <= len_d;
            loops_q <= loops_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            stop_q  <= stop_d;
        end
    end

    // Config is captured on entry to LOAD so it is stable a full cycle before the FIRE pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q <= '0;
        end else if (load_cfg) begin
            cfg_q <= tbl_q[idx_d];
        end
    end

`ifdef USER_PULSER_SEQ_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= done_set | err_set;
        end
    end

    assign irq_o = irq_q;
`endif

    assign busy_o           = (state_q != StIdle);
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign cur_idx_o        = idx_q;
    assign pass_cnt_o       = pass_q;
    assign pls_start_o      = (state_q == StFire);
    assign pls_stop_o       = stop_q;
    assign pls_f1_high_o    = cfg_q.f1_high;
    assign pls_f1_end_o     = cfg_q.f1_end;
    assign pls_f2_high_o    = cfg_q.f2_high;
    assign pls_f2_end_o     = cfg_q.f2_end;
    assign pls_f1_count_o   = cfg_q.f1_cnt;
    assign pls_f2_count_o   = cfg_q.f2_cnt;
    assign pls_stop_count_o = cfg_q.stop_cnt;

endmodule

// File: tb/tb_user_pulser_sequencer.sv
// Bench for user_pulser_sequencer: directed scenarios plus random traffic, checked every cycle
// against a behavioural model and a simple pulser model.
module tb_user_pulser_sequencer;

    localparam int DEPTH = 8;
    localparam int TMO   = 16;
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_FIRE = 2, PH_ARM = 3, PH_RUN = 4, PH_NEXT = 5,
                   PH_DRAIN = 6;

    logic        clk, rst;
    logic        tbl_we;
    logic [4:0]  tbl_addr;
    logic [31:0] tbl_wdata;
    logic        seq_start, seq_abort;
    logic [3:0]  seq_len;
    logic [7:0]  seq_loops;
    logic        busy_o, done_o, err_o;
    logic [2:0]  cur_idx_o;
    logic [7:0]  pass_cnt_o;
    logic        pls_start_o, pls_stop_o;
    logic [15:0] pls_f1_high_o, pls_f1_end_o, pls_f2_high_o, pls_f2_end_o;
    logic [7:0]  pls_f1_count_o, pls_f2_count_o, pls_stop_count_o;
    logic [2:0]  pls_state;
    logic        irq_o;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 0;

    user_pulser_sequencer #(.Depth(DEPTH), .ArmTimeout(TMO)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .tbl_we_i        (tbl_we),
        .tbl_addr_i      (tbl_addr),
        .tbl_wdata_i     (tbl_wdata),
        .seq_start_i     (seq_start),
        .seq_abort_i     (seq_abort),
        .seq_len_i       (seq_len),
        .seq_loops_i     (seq_loops),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .cur_idx_o       (cur_idx_o),
        .pass_cnt_o      (pass_cnt_o),
        .pls_start_o     (pls_start_o),
        .pls_stop_o      (pls_stop_o),
        .pls_f1_high_o   (pls_f1_high_o),
        .pls_f1_end_o    (pls_f1_end_o),
        .pls_f2_high_o   (pls_f2_high_o),
        .pls_f2_end_o    (pls_f2_end_o),
        .pls_f1_count_o  (pls_f1_count_o),
        .pls_f2_count_o  (pls_f2_count_o),
        .pls_stop_count_o(pls_stop_count_o),
`ifdef USER_PULSER_SEQ_IRQ_EN
        .irq_o           (irq_o),
`endif
        .pls_state_i     (pls_state)
    );

`ifndef USER_PULSER_SEQ_IRQ_EN
    assign irq_o = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pulser model. p_mode: 0 idle, 1 start pending, 2 running, 3 done, 4 stopping.
    int p_mode, p_cnt;
    int p_busy_dly, p_run_len, p_stop_dly;
    bit p_dead;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p_mode = 0;
            p_cnt  = 0;
            pls_state <= 3'd0;
        end else begin
            if (pls_stop_o && (p_mode == 1 || p_mode == 2)) begin
                if (p_mode == 1 || p_stop_dly == 0) p_mode = 0;
                else begin
                    p_mode = 4;
                    p_cnt  = p_stop_dly;
                end
            end else if (pls_start_o && !p_dead && (p_mode == 0 || p_mode == 3)) begin
                if (p_busy_dly == 0) begin
                    p_mode = 2;
                    p_cnt  = p_run_len;
                end else begin
                    p_mode = 1;
                    p_cnt  = p_busy_dly;
                end
            end else begin
                case (p_mode)
                    1: begin
                        p_cnt--;
                        if (p_cnt == 0) begin
                            p_mode = 2;
                            p_cnt  = p_run_len;
                        end
                    end
                    2: begin
                        p_cnt--;
                        if (p_cnt == 0) p_mode = 3;
                    end
                    4: begin
                        p_cnt--;
                        if (p_cnt == 0) p_mode = 0;
                    end
                    default: ;
                endcase
            end
            pls_state <= (p_mode == 2 || p_mode == 4) ? 3'd2 : (p_mode == 3) ? 3'd4 : 3'd0;
        end
    end

    // Reference model: table as raw 32-bit words, run as integer phase/entry/pass counters.
    int          m_ph, m_idx, m_pass, m_len, m_loops, m_wait;
    bit          m_done, m_err, m_stop, m_irq;
    logic [31:0] m_tbl [DEPTH][3];
    logic [31:0] m_cfg [3];
    bit          mb_busy, mb_rdy;
    int          mb_e, mb_w;

    function automatic void m_load();
        for (int k = 0; k < 3; k++) m_cfg[k] = m_tbl[m_idx][k];
    endfunction

    function automatic void m_fail();
        m_err = 1;
        m_irq = 1;
        m_ph  = PH_IDLE;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = PH_IDLE; m_idx = 0; m_pass = 0; m_len = 0; m_loops = 0; m_wait = 0;
            m_done = 0; m_err = 0; m_stop = 0; m_irq = 0;
            for (int e = 0; e < DEPTH; e++)
                for (int w = 0; w < 3; w++) m_tbl[e][w] = 32'h0;
            for (int k = 0; k < 3; k++) m_cfg[k] = 32'h0;
        end else begin
            mb_busy = (m_ph != PH_IDLE);
            mb_rdy  = (pls_state == 3'd0) || (pls_state == 3'd4);
            m_stop  = 0;
            m_irq   = 0;
            if (seq_abort && m_ph != PH_IDLE) begin
                m_stop = 1;
                m_ph   = PH_DRAIN;
                m_wait = 0;
            end else begin
                case (m_ph)
                    PH_IDLE: if (seq_start) begin
                        if (int'(seq_len) < 1 || int'(seq_len) > DEPTH) begin
                            m_err = 1;
                            m_irq = 1;
                        end else begin
                            m_done = 0; m_err = 0; m_idx = 0; m_pass = 0;
                            m_len   = int'(seq_len);
                            m_loops = (seq_loops == 0) ? 1 : int'(seq_loops);
                            m_load();
                            m_ph = PH_LOAD;
                        end
                    end
                    PH_LOAD: m_ph = PH_FIRE;
                    PH_FIRE: begin
                        m_ph   = PH_ARM;
                        m_wait = 0;
                    end
                    PH_ARM: begin
                        if (!mb_rdy) m_ph = PH_RUN;
                        else begin
                            m_wait++;
                            if (m_wait == TMO) m_fail();
                        end
                    end
                    PH_RUN: if (pls_state == 3'd4) m_ph = PH_NEXT;
                    PH_NEXT: begin
                        if (m_idx + 1 < m_len) begin
                            m_idx++;
                            m_load();
                            m_ph = PH_LOAD;
                        end else begin
                            m_pass = (m_pass < 255) ? m_pass + 1 : 255;
                            if (m_pass == m_loops) begin
                                m_done = 1;
                                m_irq  = 1;
                                m_ph   = PH_IDLE;
                            end else begin
                                m_idx = 0;
                                m_load();
                                m_ph = PH_LOAD;
                            end
                        end
                    end
                    PH_DRAIN: begin
                        if (mb_rdy) m_ph = PH_IDLE;
                        else begin
                            m_wait++;
                            if (m_wait == TMO) m_fail();
                        end
                    end
                    default: m_ph = PH_IDLE;
                endcase
            end
            mb_e = int'(tbl_addr) >> 2;
            mb_w = int'(tbl_addr) & 3;
            if (tbl_we && !mb_busy && mb_w != 3 && mb_e < DEPTH) m_tbl[mb_e][mb_w] = tbl_wdata;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("busy", busy_o, m_ph != PH_IDLE);
            check("done", done_o, m_done);
            check("err", err_o, m_err);
            check("cur_idx", cur_idx_o, m_idx);
            check("pass_cnt", pass_cnt_o, m_pass);
            check("pls_start", pls_start_o, m_ph == PH_FIRE);
            check("pls_stop", pls_stop_o, m_stop);
            check("cfg_f1", {pls_f1_end_o, pls_f1_high_o}, m_cfg[0]);
            check("cfg_f2", {pls_f2_end_o, pls_f2_high_o}, m_cfg[1]);
            check("cfg_cnt", {pls_stop_count_o, pls_f2_count_o, pls_f1_count_o}, m_cfg[2][23:0]);
`ifdef USER_PULSER_SEQ_IRQ_EN
            check("irq", irq_o, m_irq);
`endif
        end
    end

    // Event monitor for the directed scenarios.
    int start_cnt, stop_cnt, irq_cnt;
    int start_idx [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (pls_start_o) begin
                start_cnt++;
                start_idx.push_back(int'(cur_idx_o));
            end
            if (pls_stop_o) stop_cnt++;
            if (irq_o) irq_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int entry, input int word, input logic [31:0] data);
        tbl_we    = 1'b1;
        tbl_addr  = 5'((entry << 2) | word);
        tbl_wdata = data;
        cyc(1);
        tbl_we    = 1'b0;
    endtask

    task automatic start(input int len, input int loops);
        seq_len   = 4'(len);
        seq_loops = 8'(loops);
        seq_start = 1'b1;
        cyc(1);
        seq_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        while (busy_o && n < max_cyc) begin
            cyc(1);
            n++;
        end
        check(name, busy_o, 1'b0);
    endtask

    int n, bc, s_before;

    initial begin
        rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        seq_start = 1'b0; seq_abort = 1'b0; seq_len = '0; seq_loops = '0;
        p_busy_dly = 0; p_run_len = 10; p_stop_dly = 1; p_dead = 0;
        start_cnt = 0; stop_cnt = 0; irq_cnt = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1;
        @(negedge clk);
        check("reset busy", busy_o, 1'b0);
        check("reset done/err", {done_o, err_o}, 2'b00);
        check("reset cfg", {pls_f1_high_o, pls_stop_count_o}, 24'h0);
        cyc(1);

        // Scenario 1: config visible at LOAD, start pulse exactly two cycles after seq_start.
        wr(0, 0, 32'h0010_0004);
        wr(0, 2, 32'h0001_0203);
        start(1, 1);
        @(negedge clk);
        check("s1 f1_high", pls_f1_high_o, 16'd4);
        check("s1 f1_end", pls_f1_end_o, 16'd16);
        check("s1 counts", {pls_stop_count_o, pls_f2_count_o, pls_f1_count_o}, 24'h01_02_03);
        check("s1 start at +1", pls_start_o, 1'b0);
        cyc(1);
        @(negedge clk);
        check("s1 start at +2", pls_start_o, 1'b1);
        wait_idle(100, "s1 idle");

        // Scenario 2: three entries, two passes.
        wr(1, 0, 32'h0022_0011);
        wr(2, 1, 32'h0044_0033);
        start_idx.delete();
        irq_cnt = 0;
        start(3, 2);
        wait_idle(1000, "s2 idle");
        check("s2 start pulses", start_idx.size(), 6);
        for (int i = 0; i < start_idx.size() && i < 6; i++) check("s2 start idx", start_idx[i], i % 3);
        check("s2 done", done_o, 1'b1);
        check("s2 pass_cnt", pass_cnt_o, 8'd2);
`ifdef USER_PULSER_SEQ_IRQ_EN
        check("s2 irq pulses", irq_cnt, 1);
`endif

        // Scenario 3: abort during RUN on entry 1.
        stop_cnt = 0;
        p_stop_dly = 4;
        start(3, 1);
        n = 0;
        while (!(cur_idx_o == 3'd1 && pls_state == 3'd2) && n < 200) begin
            cyc(1);
            n++;
        end
        check("s3 reached entry1", n < 200, 1'b1);
        cyc(2);
        seq_abort = 1'b1;
        cyc(1);
        seq_abort = 1'b0;
        @(negedge clk);
        check("s3 busy in drain", busy_o, 1'b1);
        cyc(2);
        check("s3 busy while stopping", busy_o, 1'b1);
        wait_idle(100, "s3 idle");
        check("s3 stop pulses", stop_cnt, 1);
        check("s3 done/err", {done_o, err_o}, 2'b00);

        // Scenario 4: illegal lengths, then a valid start clears err.
        p_stop_dly = 1;
        s_before = start_cnt;
        start(0, 1);
        @(negedge clk);
        check("s4 err len0", err_o, 1'b1);
        start(DEPTH + 1, 1);
        cyc(2);
        check("s4 err len9", {err_o, busy_o}, 2'b10);
        check("s4 no start", start_cnt, s_before);
        start(1, 1);
        @(negedge clk);
        check("s4 err cleared", err_o, 1'b0);
        wait_idle(100, "s4 idle");

        // Scenario 5: pulser never responds, arm timeout.
        p_dead = 1;
        irq_cnt = 0;
        start(1, 1);
        bc = 0;
        while (busy_o && bc < 100) begin
            bc++;
            cyc(1);
        end
        check("s5 busy cycles", bc, 18);
        check("s5 err/busy", {err_o, busy_o}, 2'b10);
`ifdef USER_PULSER_SEQ_IRQ_EN
        check("s5 irq pulses", irq_cnt, 1);
`endif
        p_dead = 0;

        // Scenario 6: write while busy is dropped.
        wr(1, 0, 32'h0030_0020);
        start(2, 1);
        cyc(3);
        wr(1, 0, 32'hdead_beef);
        wait_idle(200, "s6 idle a");
        start(2, 1);
        wait_idle(200, "s6 idle b");
        check("s6 entry1 kept", {pls_f1_end_o, pls_f1_high_o}, 32'h0030_0020);

        // Random traffic.
        for (int c = 0; c < 6000; c++) begin
            seq_start = ($urandom_range(0, 29) == 0);
            seq_len   = 4'($urandom_range(0, DEPTH + 1));
            seq_loops = 8'($urandom_range(0, 3));
            seq_abort = ($urandom_range(0, 79) == 0);
            tbl_we    = ($urandom_range(0, 3) == 0);
            tbl_addr  = 5'($urandom);
            tbl_wdata = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                p_busy_dly = $urandom_range(0, 3);
                p_run_len  = $urandom_range(1, 12);
                case ($urandom_range(0, 3))
                    0: p_stop_dly = 0;
                    1: p_stop_dly = 1;
                    2: p_stop_dly = 3;
                    default: p_stop_dly = 20;
                endcase
                p_dead = ($urandom_range(0, 5) == 0);
            end
            rst = ($urandom_range(0, 1499) == 0);
            cyc(1);
        end
        rst = 1'b0; seq_start = 1'b0; seq_abort = 1'b0; tbl_we = 1'b0;
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
